boron_sbox_layer: RTL
=====================

# boron_sbox_layer

Parametrised, sequential successor to the 64-bit combinational Boron substitution layer. It accepts one DATA_W-bit state word over a valid/ready handshake and applies the Boron 4-bit S-box, or its inverse for decryption, to every nibble. It processes NPC nibbles per clock, which trades area for latency, and holds the result under output back-pressure. It sits between the key-add and permutation stages of the Boron round datapath.

## Interface
- DATA_W, 64, state width in bits; multiple of 4.
- NPC, 4, nibbles substituted per cycle; must divide DATA_W/4.
- INV_EN, 1, 1 = inverse S-box path built; 0 = forward only, `in_inv` ignored.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  DATA_W  state word; nibble i = bits [4i+3:4i].
- `in_inv`  in  1  1 = apply inverse S-box; sampled on acceptance.
- `out_valid`  out  1  result word present.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  DATA_W  substituted word.
- `busy`  out  1  block is not in IDLE.

## Operation
- Derived: G = DATA_W/(4·NPC) groups; counter width = max(1, clog2(G)).
- Forward S-box, index 0..F: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
- Inverse S-box, index 0..F: A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B.
- FSM states are IDLE, RUN and DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, load `in_data` into the working register, latch the mode (`in_inv`&INV_EN), clear the group counter, and go to RUN.
- RUN: each cycle, replace nibbles [cnt·NPC .. cnt·NPC+NPC-1] of the working register with their S-box or inverse S-box values. Groups run LSB first. The counter increments each cycle. After group G-1, go to DONE.
- DONE: `out_valid`=1 and `out_data` = working register. On `out_ready`, the word is consumed:
  - if `in_valid` is also high, accept the new word in the same cycle and go to RUN;
  - otherwise go to IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). The combinational path from `out_ready` to `in_ready` is intentional and enables back-to-back operation.
- `in_data` and `in_inv` are ignored while in RUN, and in DONE without `out_ready`.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0. It is not cleared on consumption.
- Reset: state=IDLE; working register, counter and mode are cleared to 0. Reset has priority over any handshake and aborts an in-flight word with no output.

## Timing
- Reset values: `in_ready`=1 after the reset edge; `out_valid`=0, `out_data`=0, `busy`=0.
- Latency: acceptance at edge k gives `out_valid`=1 in the cycle after edge k+G. For the defaults (G=4), that is 4 cycles.
- NPC = DATA_W/4 gives G=1 and 1-cycle latency.
- Throughput: one word per G+1 cycles when there is no back-pressure.
- `busy`=1 in RUN and DONE.

## Structure
- Package `boron_pkg` contains:
  - `SBOX` and `INV_SBOX` as 16×4-bit constant arrays;
  - functions `sbox4(nib)` and `inv_sbox4(nib)`;
  - the FSM state enum `sbox_state_t`.
- Sub-module `boron_sbox_nibble`: a 4-bit combinational forward/inverse lookup with an `inv` select, instantiated NPC times and muxed into the selected group.
- A parameter check fails elaboration if DATA_W%4≠0 or (DATA_W/4)%NPC≠0.

## Test plan
- Defaults, forward, `in_data`=0x0000000000000000 → `out_valid` 4 cycles after acceptance, `out_data`=0xEEEEEEEEEEEEEEEE.
- Forward, `in_data`=0x0123456789ABCDEF → 0xE4B179CAD20F8536; inverse of that word → 0x0123456789ABCDEF.
- Back-pressure: hold `out_ready`=0 for 6 cycles in DONE → `out_data` stable, `in_ready`=0, `busy`=1; release → one transfer only.
- Back-to-back: `in_valid`=1 continuously and `out_ready`=1, alternating `in_inv` → outputs every 5 cycles with the correct per-word mode, and no word dropped or duplicated.
- Assert `rst` at the second RUN cycle → next cycle is IDLE, `out_valid`=0, `out_data`=0, and no output is produced for the aborted word.
- NPC=16, DATA_W=64: latency 1. DATA_W=128, NPC=8: G=4, and 0x0123456789ABCDEF0123456789ABCDEF gives 0xE4B179CAD20F8536E4B179CAD20F8536.

Source files
------------

// File: rtl/boron_pkg.sv
// Shared definitions for the Boron substitution layer: S-box tables, lookup
// helpers and the FSM state encoding.
package boron_pkg;

   localparam logic [3:0] SBOX [16] = '{
      4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
      4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
      4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sbox_state_t;

   function automatic logic [3:0] sbox4(input logic [3:0] nib);
      return SBOX[nib];
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] nib);
      return INV_SBOX[nib];
   endfunction

endpackage

// File: rtl/boron_sbox_nibble.sv
// One 4-bit Boron S-box lookup; the inverse table only exists when INV_EN is set.
module boron_sbox_nibble
   import boron_pkg::*;
#(
   parameter bit INV_EN = 1'b1
) (
   input  logic [3:0] nib_i,
   input  logic       inv_i,
   output logic [3:0] nib_o
);

   assign nib_o = (INV_EN && inv_i) ? inv_sbox4(nib_i) : sbox4(nib_i);

endmodule

// File: rtl/boron_sbox_layer.sv
// Sequential Boron S-box layer: substitutes NPC nibbles per cycle, LSB group
// first, and holds the finished word until the consumer takes it.
module boron_sbox_layer
   import boron_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NPC    = 4,
   parameter bit INV_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam int NIB   = DATA_W / 4;
   localparam int G     = NIB / NPC;
   localparam int CNT_W = (G > 1) ? $clog2(G) : 1;

   if ((DATA_W % 4) != 0 || (NIB % NPC) != 0) begin : g_param_err
      $error("boron_sbox_layer: DATA_W must be a multiple of 4 and NPC must divide DATA_W/4");
   end

   sbox_state_t       state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d, work_run;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              inv_q, inv_d;
   logic              accept;
   logic [3:0]        grp_nib [NPC];
   logic [3:0]        sub_nib [NPC];

   assign accept = in_valid & in_ready;

   // Gather the nibbles of the active group onto the NPC lookup lanes.
   always_comb begin
      for (int l = 0; l < NPC; l++) grp_nib[l] = '0;
      for (int g = 0; g < G; g++) begin
         if (cnt_q == CNT_W'(g)) begin
            for (int l = 0; l < NPC; l++) grp_nib[l] = work_q[(g*NPC + l)*4 +: 4];
         end
      end
   end

   genvar gi;
   for (gi = 0; gi < NPC; gi++) begin : g_lane
      boron_sbox_nibble #(.INV_EN(INV_EN)) u_nib (
         .nib_i (grp_nib[gi]),
         .inv_i (inv_q),
         .nib_o (sub_nib[gi])
      );
   end

   for (gi = 0; gi < NIB; gi++) begin : g_wb
      assign work_run[gi*4 +: 4] = (cnt_q == CNT_W'(gi / NPC)) ? sub_nib[gi % NPC]
                                                               : work_q[gi*4 +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_W'(G - 1)) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // out_ready feeds in_ready combinationally so DONE can hand over and reload in one cycle.
   always_comb begin
      in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
   end

   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      inv_d  = inv_q;
      if (accept) begin
         work_d = in_data;
         cnt_d  = '0;
         inv_d  = in_inv & INV_EN;
      end else if (state_q == ST_RUN) begin
         work_d = work_run;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         cnt_q  <= '0;
         inv_q  <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         inv_q  <= inv_d;
      end
   end

   assign out_data = work_q;

endmodule
